// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters (round-robin or fixed priority).
// Latency: request accepted in cycle T, ALU evaluated in T+1, response valid from T+2; one op per 3 cycles peak.
// Backpressure: the response is held stable until its rsp ready; no request is accepted until then.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready              request handshake for requester N (ready only in IDLE, only for the winner)
//   reqN_a/b/shamt/op             operation payload for requester N
//   alu_a/b/shamt/op, alu_out     registered operands to, and combinational result from, the shared ALU
//   rspN_valid/data/ready         response handshake for requester N (data forced to 0 when not valid)
module alu_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  shamt_q;
  logic [3:0]  op_q;
  logic [31:0] res_q;
  logic        gnt_q;   // requester owning the in-flight operation
  logic        last_q;  // requester granted most recently (round-robin pointer)

  logic idle;
  logic any_valid;
  logic pick;           // requester that would win this cycle
  logic rsp_taken;

  always_comb begin
    // Qualifying with rst keeps the readies low while reset is held.
    idle      = (state == S_IDLE) && !rst;
    any_valid = req0_valid || req1_valid;
    pick      = 1'b0;
    if (PRIO_MODE != 0) begin
      pick = !req0_valid;
    end else if (req0_valid && req1_valid) begin
      pick = !last_q;
    end else begin
      pick = req1_valid;
    end
  end

  assign req0_ready = idle && any_valid && !pick;
  assign req1_ready = idle && any_valid && pick;

  // The ALU only ever sees registered operands; nothing from req*_ reaches it combinationally.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_shamt = shamt_q;
  assign alu_op    = op_q;

  assign rsp0_valid = (state == S_RESP) && !gnt_q;
  assign rsp1_valid = (state == S_RESP) && gnt_q;
  assign rsp0_data  = rsp0_valid ? res_q : 32'd0;
  assign rsp1_data  = rsp1_valid ? res_q : 32'd0;
  assign rsp_taken  = gnt_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      shamt_q <= 5'd0;
      op_q    <= 4'd0;
      res_q   <= 32'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            state   <= S_EXEC;
            gnt_q   <= pick;
            last_q  <= pick;
            a_q     <= pick ? req1_a     : req0_a;
            b_q     <= pick ? req1_b     : req0_b;
            shamt_q <= pick ? req1_shamt : req0_shamt;
            op_q    <= pick ? req1_op    : req0_op;
          end
        end
        S_EXEC: begin
          // Opcodes 12..15 are undefined: the ALU's answer is discarded.
          res_q <= (op_q[3:2] == 2'b11) ? 32'd0 : alu_out;
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_taken) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (round-robin and fixed priority) each with its own bench-side ALU.
// Outputs are compared every cycle against a transaction-level model, plus directed literal scenarios.
// Requesters hold valid/payload until accepted; response ready is randomly withheld.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // index [d] = DUT instance (0: round-robin, 1: fixed priority), [n] = requester
  logic [1:0]  v  [2];
  logic [1:0]  rr [2];
  logic [31:0] a  [2][2];
  logic [31:0] b  [2][2];
  logic [4:0]  sh [2][2];
  logic [3:0]  op [2][2];
  wire  [1:0]  rdy [2];
  wire  [1:0]  rv  [2];
  wire  [31:0] rd  [2][2];
  wire  [31:0] xa  [2];
  wire  [31:0] xb  [2];
  wire  [4:0]  xs  [2];
  wire  [3:0]  xop [2];
  wire  [31:0] xo  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Shared ALU as seen by the arbiter; undefined opcodes return junk so masking is observable.
  function automatic logic [31:0] env_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s);
    case (o)
      4'd0, 4'd1: return x + y;
      4'd2, 4'd3: return x - y;
      4'd4:       return x & y;
      4'd5:       return x | y;
      4'd6:       return x ^ y;
      4'd7:       return ~(x | y);
      4'd8:       return y << s;
      4'd9:       return y << x[4:0];
      4'd10:      return y >> s;
      4'd11:      return y >> x[4:0];
      default:    return x | 32'd1;
    endcase
  endfunction

  assign xo[0] = env_alu(xop[0], xa[0], xb[0], xs[0]);
  assign xo[1] = env_alu(xop[1], xa[1], xb[1], xs[1]);

  alu_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v[0][0]), .req0_ready(rdy[0][0]), .req0_a(a[0][0]), .req0_b(b[0][0]),
    .req0_shamt(sh[0][0]), .req0_op(op[0][0]),
    .req1_valid(v[0][1]), .req1_ready(rdy[0][1]), .req1_a(a[0][1]), .req1_b(b[0][1]),
    .req1_shamt(sh[0][1]), .req1_op(op[0][1]),
    .alu_a(xa[0]), .alu_b(xb[0]), .alu_shamt(xs[0]), .alu_op(xop[0]), .alu_out(xo[0]),
    .rsp0_valid(rv[0][0]), .rsp0_data(rd[0][0]), .rsp0_ready(rr[0][0]),
    .rsp1_valid(rv[0][1]), .rsp1_data(rd[0][1]), .rsp1_ready(rr[0][1])
  );

  alu_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v[1][0]), .req0_ready(rdy[1][0]), .req0_a(a[1][0]), .req0_b(b[1][0]),
    .req0_shamt(sh[1][0]), .req0_op(op[1][0]),
    .req1_valid(v[1][1]), .req1_ready(rdy[1][1]), .req1_a(a[1][1]), .req1_b(b[1][1]),
    .req1_shamt(sh[1][1]), .req1_op(op[1][1]),
    .alu_a(xa[1]), .alu_b(xb[1]), .alu_shamt(xs[1]), .alu_op(xop[1]), .alu_out(xo[1]),
    .rsp0_valid(rv[1][0]), .rsp0_data(rd[1][0]), .rsp0_ready(rr[1][0]),
    .rsp1_valid(rv[1][1]), .rsp1_data(rd[1][1]), .rsp1_ready(rr[1][1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each instance is either free or holds one operation accepted in cycle m_acc;
  // its response is visible from cycle m_acc+2 until the owner's rsp ready is seen at an edge.
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_last [2] = '{1'b1, 1'b1};
  int          m_acc  [2];
  int          m_gid  [2];
  logic [31:0] m_res  [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [4:0]  m_s    [2];
  logic [3:0]  m_o    [2];
  int          eg     [2];   // requester the model expects to be granted now, -1 for none

  function automatic int exp_grant(input int d, input logic [1:0] vv, input logic last);
    if (vv == 2'b00) return -1;
    if (d == 1) return vv[0] ? 0 : 1;      // instance 1 is fixed priority
    if (vv == 2'b11) return last ? 0 : 1;  // tie: whoever did not win last time
    return vv[1] ? 1 : 0;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      eg[d] = m_busy[d] ? -1 : exp_grant(d, v[d], m_last[d]);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] <= 1'b0;
        m_last[d] <= 1'b1;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (eg[d] >= 0) begin
          m_busy[d] <= 1'b1;
          m_acc[d]  <= cyc;
          m_gid[d]  <= eg[d];
          m_last[d] <= (eg[d] == 1);
          m_a[d]    <= a[d][eg[d]];
          m_b[d]    <= b[d][eg[d]];
          m_s[d]    <= sh[d][eg[d]];
          m_o[d]    <= op[d][eg[d]];
          m_res[d]  <= (op[d][eg[d]] >= 4'd12) ? 32'd0
                       : env_alu(op[d][eg[d]], a[d][eg[d]], b[d][eg[d]], sh[d][eg[d]]);
        end else if (m_busy[d] && cyc >= m_acc[d] + 2 && rr[d][m_gid[d]]) begin
          m_busy[d] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] ce [2];
  logic [1:0] cv [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk($sformatf("d%0d_rst_rdy", d), 32'(rdy[d]), 32'd0);
        chk($sformatf("d%0d_rst_rv", d), 32'(rv[d]), 32'd0);
        chk($sformatf("d%0d_rst_rd0", d), rd[d][0], 32'd0);
        chk($sformatf("d%0d_rst_rd1", d), rd[d][1], 32'd0);
        chk($sformatf("d%0d_rst_alu", d), xa[d] | xb[d] | 32'(xs[d]) | 32'(xop[d]), 32'd0);
      end else begin
        ce[d] = (eg[d] < 0) ? 2'b00 : (eg[d] == 0) ? 2'b01 : 2'b10;
        cv[d] = (m_busy[d] && cyc >= m_acc[d] + 2) ? ((m_gid[d] == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(ce[d]));
        chk($sformatf("d%0d_rsp_valid", d), 32'(rv[d]), 32'(cv[d]));
        chk($sformatf("d%0d_rsp0_data", d), rd[d][0], cv[d][0] ? m_res[d] : 32'd0);
        chk($sformatf("d%0d_rsp1_data", d), rd[d][1], cv[d][1] ? m_res[d] : 32'd0);
        if (m_busy[d]) begin
          chk($sformatf("d%0d_alu_a", d), xa[d], m_a[d]);
          chk($sformatf("d%0d_alu_b", d), xb[d], m_b[d]);
          chk($sformatf("d%0d_alu_shamt", d), 32'(xs[d]), 32'(m_s[d]));
          chk($sformatf("d%0d_alu_op", d), 32'(xop[d]), 32'(m_o[d]));
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  // All helpers start and end just after a rising edge.
  task automatic single_op(input int d, input int n, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] s, input logic [31:0] want,
                           input string nm);
    a[d][n] = x; b[d][n] = y; sh[d][n] = s; op[d][n] = o; v[d][n] = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(rdy[d]), 32'd1 << n);
    @(posedge clk); #1 v[d][n] = 1'b0;
    @(negedge clk);
    chk({nm, "_exec_valid"}, 32'(rv[d]), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rv[d]), 32'd1 << n);
    chk({nm, "_data"}, rd[d][n], want);
    chk({nm, "_other_data"}, rd[d][1-n], 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input int d, output logic [1:0] got);
    got = 2'b00;
    for (int k = 0; k < 12 && got == 2'b00; k++) begin
      @(negedge clk);
      got = rdy[d];
    end
  endtask

  logic [1:0] got;
  logic [1:0] took [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = 2'b00; rr[d] = 2'b11;
      for (int n = 0; n < 2; n++) begin
        a[d][n] = 32'd0; b[d][n] = 32'd0; sh[d][n] = 5'd0; op[d][n] = 4'd0;
      end
    end
    #1 rst = 1'b1;
    #2;
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_rsp_valid", 32'(rv[1]), 32'd0);
    chk("reset_alu_a", xa[0], 32'd0);
    chk("reset_alu_op", 32'(xop[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // accepted in the first cycle after release, answer two cycles later
    single_op(0, 0, 4'd0, 32'd5, 32'd7, 5'd0, 32'd12, "add_5_7");

    // round-robin tie: requester 0 just won, so requester 1 goes first now
    a[0][0] = 32'd1; b[0][0] = 32'd1; op[0][0] = 4'd0;
    a[0][1] = 32'd3; b[0][1] = 32'd5; op[0][1] = 4'd2;
    v[0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(0, got);
      chk("rr_grant", 32'(got), (k % 2 == 0) ? 32'd2 : 32'd1);
      @(negedge clk); @(negedge clk);
      if (got == 2'b10) chk("rr_sub_3_5", rd[0][1], 32'hFFFF_FFFE);
      else              chk("rr_add_1_1", rd[0][0], 32'd2);
    end
    @(posedge clk); #1 v[0] = 2'b00;

    // fixed priority tie: requester 0 always wins while valid
    a[1][0] = 32'd1; b[1][0] = 32'd2; op[1][0] = 4'd0;
    a[1][1] = 32'hF0; b[1][1] = 32'h0F; op[1][1] = 4'd6;
    v[1] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_rdy(1, got);
      chk("fp_grant", 32'(got), 32'd1);
      @(negedge clk); @(negedge clk);
      chk("fp_rsp0", rd[1][0], 32'd3);
    end
    @(posedge clk); #1 v[1][0] = 1'b0;
    wait_rdy(1, got);
    chk("fp_req1_after_drop", 32'(got), 32'd2);
    @(negedge clk); @(negedge clk);
    chk("fp_rsp1_xor", rd[1][1], 32'hFF);
    @(posedge clk); #1 v[1][1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // backpressure on requester 1's response
    rr[0][1] = 1'b0;
    a[0][1] = $urandom; b[0][1] = 32'd1; sh[0][1] = 5'd4; op[0][1] = 4'd8; v[0][1] = 1'b1;
    wait_rdy(0, got);
    chk("bp_accept", 32'(got), 32'd2);
    @(posedge clk); #1 v[0][1] = 1'b0;
    a[0][0] = 32'd6; b[0][0] = 32'd1; op[0][0] = 4'd0; v[0][0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rv[0]), 32'd2);
      chk("bp_data", rd[0][1], 32'd16);
      chk("bp_no_accept", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk); #1 rr[0][1] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rv[0]), 32'd2);
    chk("bp_release_no_accept", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("bp_req0_accept", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1 v[0][0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // undefined opcode yields 0, then a variable right shift
    single_op(0, 0, 4'd13, 32'h1234, 32'h5678, 5'd0, 32'd0, "illegal_op13");
    single_op(0, 0, 4'd11, 32'd2, 32'h8000_0000, 5'd0, 32'h2000_0000, "srlv");

    // reset while the operation is in EXEC
    a[0][0] = 32'd9; b[0][0] = 32'd9; op[0][0] = 4'd0; v[0][0] = 1'b1;
    @(negedge clk);
    chk("rx_accept", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1 v[0][0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rx_async_valid", 32'(rv[0]), 32'd0);
    chk("rx_async_alu_a", xa[0], 32'd0);
    chk("rx_async_alu_b", xb[0], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rx_no_rsp", 32'(rv[0]), 32'd0);
    end
    @(posedge clk); #1;
    single_op(0, 0, 4'd0, 32'd20, 32'd22, 5'd0, 32'd42, "post_reset_add");

    // random traffic on both instances, one reset pulse mid-run
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) took[d] = v[d] & rdy[d];
      @(posedge clk); #1;
      if (it == 1500) rst = 1'b1;
      if (it == 1502) rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        for (int n = 0; n < 2; n++) begin
          if (took[d][n]) v[d][n] = 1'b0;
          if (!v[d][n] && $urandom_range(0, 2) == 0) begin
            a[d][n]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b[d][n]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            sh[d][n] = 5'($urandom);
            op[d][n] = 4'($urandom_range(0, 15));
            v[d][n]  = 1'b1;
          end
        end
        rr[d] = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
      end
    end
    v[0] = 2'b00; v[1] = 2'b00; rr[0] = 2'b11; rr[1] = 2'b11;
    repeat (6) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
